// File: rtl/display_scheduler.sv
// Round-robin arbiter sharing one display path between four counter clients.
// Latency: request sampled at an IDLE edge -> ack/disp_ready/data registered the next cycle.
// Backpressure: clients hold req until acked; each grant then dwells delay*PRESCALE cycles.
module display_scheduler #(
    parameter int PRESCALE = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic        reverse_order,
    input  logic [4:0]  delay,
    output logic [3:0]  ack,
    output logic        disp_ready,
    output logic [7:0]  disp_data,
    output logic [1:0]  client_number,
    output logic        busy
);

    // A one-cycle prescale period still needs a 1-bit counter that never leaves 0.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      last_grant;
    logic [PW-1:0]   prescale_cnt;
    logic [4:0]      tick_cnt;
    logic [4:0]      dwell_len;

    logic [1:0]      winner;
    logic [1:0]      cand;
    logic            found;
    logic            grant;
    logic            tick;
    logic            dwell_done;

    // Search the three clients after (or before) the last winner, then the last winner itself.
    always_comb begin
        winner = last_grant;
        cand   = last_grant;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = reverse_order ? (last_grant - 2'(k)) : (last_grant + 2'(k));
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign grant      = (state == IDLE) && enable && found;
    assign tick       = (state == DWELL) && (prescale_cnt == PS_LAST);
    assign dwell_done = tick && ((tick_cnt + 5'd1) == dwell_len);
    assign busy       = (state == DWELL);

    // State register; reset aborts any dwell in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: grant moves to DWELL, the final tick of the dwell returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant)      state_nxt = DWELL;
            DWELL:   if (dwell_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant outputs: data/client latched at the grant edge, ack/ready pulse for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack           <= 4'b0000;
            disp_ready    <= 1'b0;
            disp_data     <= 8'h00;
            client_number <= 2'd0;
            last_grant    <= 2'd0;
            dwell_len     <= 5'd0;
        end else if (grant) begin
            ack           <= 4'b0001 << winner;
            disp_ready    <= 1'b1;
            disp_data     <= req_data[{winner, 3'b000} +: 8];
            client_number <= winner;
            last_grant    <= winner;
            dwell_len     <= (delay == 5'd0) ? 5'd1 : delay;
        end else begin
            ack        <= 4'b0000;
            disp_ready <= 1'b0;
        end
    end

    // Dwell timing: prescaler wraps into a tick, ticks count up to the latched dwell length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_cnt <= '0;
            tick_cnt     <= 5'd0;
        end else if (grant) begin
            prescale_cnt <= '0;
            tick_cnt     <= 5'd0;
        end else if (state == DWELL) begin
            if (tick) begin
                prescale_cnt <= '0;
                tick_cnt     <= tick_cnt + 5'd1;
            end else begin
                prescale_cnt <= prescale_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with PRESCALE=4.
// Latency: grants observed on the falling edge after the grant edge.
// Backpressure: inputs change on falling edges, all waits are cycle-bounded.
module tb_display_scheduler;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h44332211;
    logic        reverse_order = 1'b0;
    logic [4:0]  delay = 5'd0;
    logic [3:0]  ack;
    logic        disp_ready;
    logic [7:0]  disp_data;
    logic [1:0]  client_number;
    logic        busy;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    display_scheduler #(.PRESCALE(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .req           (req),
        .req_data      (req_data),
        .reverse_order (reverse_order),
        .delay         (delay),
        .ack           (ack),
        .disp_ready    (disp_ready),
        .disp_data     (disp_data),
        .client_number (client_number),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_grant(input int bound, output bit found, output logic [1:0] cn,
                              output logic [7:0] dd, output logic [3:0] ak, output int at);
        found = 1'b0; cn = 2'd0; dd = 8'h00; ak = 4'h0; at = 0;
        for (int i = 0; i < bound && !found; i++) begin
            @(negedge clk);
            if (disp_ready === 1'b1) begin
                found = 1'b1; cn = client_number; dd = disp_data; ak = ack; at = cyc;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0; req = 4'b0000;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit saw_activity;
        #2 rst = 1'b0;
        req = 4'b0000; enable = 1'b1;
        @(negedge clk);
        n_cmp++; if ({ack, disp_ready, disp_data, client_number, busy} !== 16'h0000) begin
            n_err++; $display("FAIL reset_outputs: got ack=%b rdy=%b data=%h cn=%0d busy=%b want all 0",
                              ack, disp_ready, disp_data, client_number, busy);
        end
        rst = 1'b1;
        saw_activity = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy !== 1'b0 || disp_ready !== 1'b0 || ack !== 4'b0000) saw_activity = 1'b1;
        end
        n_cmp++; if (saw_activity !== 1'b0) begin
            n_err++; $display("FAIL reset_idle: got activity=%b want 0 with req=0", saw_activity);
        end
    endtask

    task automatic test_round_robin(input string name, input logic rev, input logic [9:0] order);
        bit found; logic [1:0] cn; logic [7:0] dd; logic [3:0] ak; int at; int prev_at;
        logic [1:0] c; logic [7:0] exp_d;
        do_reset();
        reverse_order = rev; delay = 5'd2; req = 4'b1111; enable = 1'b1;
        prev_at = 0;
        for (int k = 0; k < 5; k++) begin
            wait_grant(40, found, cn, dd, ak, at);
            c = order[2*k +: 2];
            exp_d = 8'(17 * (int'(c) + 1));
            n_cmp++; if (found !== 1'b1) begin
                n_err++; $display("FAIL %s grant%0d timeout: got none want a grant", name, k);
            end
            n_cmp++; if (cn !== c) begin
                n_err++; $display("FAIL %s grant%0d client: got %0d want %0d", name, k, cn, c);
            end
            n_cmp++; if (dd !== exp_d) begin
                n_err++; $display("FAIL %s grant%0d data: got %h want %h", name, k, dd, exp_d);
            end
            n_cmp++; if (ak !== (4'b0001 << c)) begin
                n_err++; $display("FAIL %s grant%0d ack: got %b want %b", name, k, ak, 4'b0001 << c);
            end
            if (k > 0) begin
                n_cmp++; if (at - prev_at !== 9) begin
                    n_err++; $display("FAIL %s grant%0d spacing: got %0d want 9", name, k, at - prev_at);
                end
            end
            prev_at = at;
        end
        enable = 1'b0; req = 4'b0000;
    endtask

    task automatic test_single_delay0();
        bit found; logic [1:0] cn; logic [7:0] dd; logic [3:0] ak; int at; int prev_at;
        do_reset();
        reverse_order = 1'b0; delay = 5'd0; req = 4'b0100; enable = 1'b1;
        prev_at = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(30, found, cn, dd, ak, at);
            n_cmp++; if (found !== 1'b1 || cn !== 2'd2 || dd !== 8'h33) begin
                n_err++; $display("FAIL single grant%0d: got found=%b cn=%0d data=%h want 1/2/33", k, found, cn, dd);
            end
            n_cmp++; if (ak !== 4'b0100) begin
                n_err++; $display("FAIL single grant%0d ack: got %b want 0100", k, ak);
            end
            if (k > 0) begin
                n_cmp++; if (at - prev_at !== 5) begin
                    n_err++; $display("FAIL single grant%0d spacing: got %0d want 5", k, at - prev_at);
                end
            end
            prev_at = at;
            @(negedge clk);
            n_cmp++; if (ack !== 4'b0000 || disp_ready !== 1'b0 || busy !== 1'b1) begin
                n_err++; $display("FAIL single pulse%0d: got ack=%b rdy=%b busy=%b want 0000/0/1", k, ack, disp_ready, busy);
            end
        end
        enable = 1'b0; req = 4'b0000;
    endtask

    task automatic test_enable_withdraw();
        bit found; logic [1:0] cn; logic [7:0] dd; logic [3:0] ak; int at; int pulses;
        do_reset();
        reverse_order = 1'b0; delay = 5'd2; req = 4'b0001; enable = 1'b1;
        wait_grant(20, found, cn, dd, ak, at);
        n_cmp++; if (found !== 1'b1 || cn !== 2'd0 || dd !== 8'h11) begin
            n_err++; $display("FAIL enable first: got found=%b cn=%0d data=%h want 1/0/11", found, cn, dd);
        end
        @(negedge clk);
        enable = 1'b0; req = 4'b1111;
        n_cmp++; if (busy !== 1'b1) begin
            n_err++; $display("FAIL enable mid_dwell busy: got %b want 1", busy);
        end
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (disp_ready === 1'b1 || ack !== 4'b0000) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin
            n_err++; $display("FAIL enable blocked: got %0d grants want 0", pulses);
        end
        n_cmp++; if (busy !== 1'b0 || disp_data !== 8'h11 || client_number !== 2'd0) begin
            n_err++; $display("FAIL enable hold: got busy=%b data=%h cn=%0d want 0/11/0", busy, disp_data, client_number);
        end
        req = 4'b1101; enable = 1'b1;
        wait_grant(20, found, cn, dd, ak, at);
        n_cmp++; if (found !== 1'b1 || cn !== 2'd2 || dd !== 8'h33) begin
            n_err++; $display("FAIL enable skip: got found=%b cn=%0d data=%h want 1/2/33", found, cn, dd);
        end
        enable = 1'b0; req = 4'b0000;
    endtask

    task automatic test_reset_mid_dwell();
        bit found; logic [1:0] cn; logic [7:0] dd; logic [3:0] ak; int at;
        do_reset();
        reverse_order = 1'b0; delay = 5'd5; req = 4'b1111; enable = 1'b1;
        wait_grant(20, found, cn, dd, ak, at);
        n_cmp++; if (found !== 1'b1 || cn !== 2'd1 || dd !== 8'h22) begin
            n_err++; $display("FAIL rstmid first: got found=%b cn=%0d data=%h want 1/1/22", found, cn, dd);
        end
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b1) begin
            n_err++; $display("FAIL rstmid busy_before: got %b want 1", busy);
        end
        rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || disp_data !== 8'h00 || client_number !== 2'd0) begin
            n_err++; $display("FAIL rstmid cleared: got busy=%b data=%h cn=%0d want 0/00/0", busy, disp_data, client_number);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_grant(5, found, cn, dd, ak, at);
        n_cmp++; if (found !== 1'b1 || cn !== 2'd1 || dd !== 8'h22 || ak !== 4'b0010) begin
            n_err++; $display("FAIL rstmid regrant: got found=%b cn=%0d data=%h ack=%b want 1/1/22/0010",
                              found, cn, dd, ak);
        end
        enable = 1'b0; req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_round_robin("forward", 1'b0, {2'd1, 2'd0, 2'd3, 2'd2, 2'd1});
        test_round_robin("reverse", 1'b1, {2'd3, 2'd0, 2'd1, 2'd2, 2'd3});
        test_single_delay0();
        test_enable_withdraw();
        test_reset_mid_dwell();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Shares the display path between four requesting clients (bank-register counters) and sequences what the display controller shows. Arbitration is round-robin, and the search direction is selectable. The winner's 8-bit value is handed to the display controller with a one-cycle `ready` pulse together with its 2-bit client number. Each grant is held for a programmable dwell time before the next arbitration.

## Interface
- `PRESCALE`, default 1000: clock cycles per dwell tick (≥1).
- `clk`  in  1: clock, all state on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `enable`  in  1: arbitration enable; low blocks new grants only.
- `req`  in  4: request per client, level, held until acked.
- `req_data`  in  32: client data, client i on bits [8i+7:8i].
- `reverse_order`  in  1: 0 = ascending round-robin search, 1 = descending.
- `delay`  in  5: dwell length in ticks; 0 treated as 1.
- `ack`  out  4: one-hot, one-cycle pulse to the granted client.
- `disp_ready`  out  1: one-cycle pulse; `disp_data`/`client_number` valid.
- `disp_data`  out  8: latched data of the granted client.
- `client_number`  out  2: index of the granted client.
- `busy`  out  1: high while in DWELL.

## Operation
- FSM states: IDLE, DWELL.
- IDLE → DWELL at an edge where `enable`=1 and `req`≠0. At that edge:
  - register winner index W into `client_number`;
  - register `req_data[8W+7:8W]` into `disp_data`;
  - set `ack[W]`=1 and `disp_ready`=1;
  - latch `last_grant`=W;
  - latch `dwell_len`=max(`delay`,1);
  - clear the prescaler and tick counters.
- Winner search, based on L=`last_grant` (mod 4):
  - forward (`reverse_order`=0): L+1, L+2, L+3, L;
  - reverse (`reverse_order`=1): L−1, L−2, L−3, L;
  - first requesting client in that order wins. A lone requester may win repeatedly.
- DWELL:
  - prescaler counts 0..PRESCALE−1; wrap = tick;
  - tick counter increments per tick;
  - on the tick that makes ticks == `dwell_len`, go to IDLE.
- `ack`/`disp_ready` are high only in the first cycle after the grant edge, then low.
- `disp_data`/`client_number` hold their value until the next grant.
- `busy`=1 exactly while state==DWELL.
- `enable` low during DWELL: dwell completes normally; FSM stays in IDLE until `enable`=1.
- `req`, `delay` and `reverse_order` changes during DWELL have no effect until the next IDLE evaluation. `delay` is sampled only at the grant edge.
- A request dropped before the grant edge is not granted; no partial grant.
- `rst` low at any time: all state returns to reset values immediately, and any dwell is aborted.

## Timing
- Reset values:
  - state IDLE, `last_grant`=0, counters 0;
  - `ack`=0, `disp_ready`=0, `disp_data`=0, `client_number`=0, `busy`=0.
- After reset with forward search, client 1 has first priority; with reverse search, client 3 has first priority.
- Grant latency: `req` sampled high in IDLE at edge E → `ack`/`disp_ready` visible in the cycle after E.
- DWELL lasts `dwell_len`×PRESCALE cycles.
- IDLE lasts at least 1 cycle, so back-to-back grant edges are `dwell_len`×PRESCALE+1 cycles apart.
- Width rules:
  - prescaler ≥ clog2(PRESCALE) bits;
  - tick counter 5 bits (max 31, no overflow);
  - index arithmetic mod 4.

## Test plan
- **Reset:** PRESCALE=4, hold `rst`=0 → all outputs 0; release with `req`=0 → FSM stays IDLE, `busy`=0.
- **Round-robin forward:** `req`=4'b1111, data 0x11/0x22/0x33/0x44 for clients 0-3, `delay`=2 → grant order 1,2,3,0,1; `disp_data` 0x22,0x33,0x44,0x11; grant edges 9 cycles apart.
- **Reverse order:** same stimulus with `reverse_order`=1 → grant order 3,2,1,0,3.
- **Delay=0 and single requester:** `req`=4'b0100, `delay`=0 → client 2 granted repeatedly every 5 cycles; `ack`=4'b0100 pulses one cycle each.
- **Enable/withdraw:** drop `enable` mid-DWELL → dwell finishes, no further `ack`. Re-enable with client 1's `req` removed → client 1 skipped.
- **Reset mid-dwell:** assert `rst` 3 cycles into DWELL with `delay`=5 → `busy`, `disp_data` and `client_number` go to 0 immediately. After release, next grant follows the reset priority (client 1 first, forward).
